// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the text-mode video fetch owns fixed slots and
// the CPU gets the remaining cycles in three-cycle transactions.
module vram_arbiter #(
  parameter logic [15:0] VID_BASE = 16'h0000,
  parameter int unsigned H_MAX    = 799,
  parameter int unsigned V_MAX    = 524
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_on,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  vid_data,
  output logic        vid_valid
);

  typedef enum logic [2:0] {
    IDLE,
    VID,
    VWAIT,
    CPU,
    CWAIT
  } state_e;

  localparam logic [9:0] H_PRE  = 10'(H_MAX - 2);
  localparam logic [9:0] H_BLK  = 10'(H_MAX - 4);
  localparam logic [9:0] V_LAST = 10'(V_MAX);

  state_e      state_q;
  logic [15:0] ram_addr_q;
  logic        ram_we_q;
  logic [7:0]  ram_wdata_q;
  logic        cpu_ack_q;
  logic [7:0]  cpu_rdata_q;
  logic [7:0]  vid_data_q;
  logic        vid_valid_q;
  logic        rd_q;

  logic        vslot;
  logic        cblock;
  logic        eol;
  logic        cgrant;
  logic [5:0]  row_d;
  logic [6:0]  col_d;
  logic [15:0] vaddr_d;

  always_comb begin
    eol    = (hpos == H_PRE);
    vslot  = (hpos[2:0] == 3'd5)
           && (display_on || eol);
    cblock = (hpos[2:0] inside {3'd3, 3'd4, 3'd5})
           && (display_on
               || ((hpos >= H_BLK) && (hpos <= H_PRE)));
    cgrant = cpu_req && !cblock && !cpu_ack_q;
    row_d  = vpos[8:3];
    col_d  = hpos[9:3] + 7'd1;
    // End-of-line prefetch targets cell 0 of the next line
    if (eol) begin
      col_d = 7'd0;
      if (vpos == V_LAST) row_d = 6'd0;
      else row_d = vpos[8:3] + {5'd0, &vpos[2:0]};
    end
    vaddr_d = VID_BASE + {3'b000, row_d, col_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (vslot) begin
            state_q    <= VID;
            ram_addr_q <= vaddr_d;
            ram_we_q   <= 1'b0;
          end else if (cgrant) begin
            state_q     <= CPU;
            ram_addr_q  <= cpu_addr;
            ram_we_q    <= cpu_we;
            ram_wdata_q <= cpu_wdata;
            rd_q        <= !cpu_we;
          end
        end
        VID: state_q <= VWAIT;
        VWAIT: begin
          state_q     <= IDLE;
          vid_data_q  <= ram_rdata;
          vid_valid_q <= 1'b1;
        end
        CPU: begin
          state_q  <= CWAIT;
          ram_we_q <= 1'b0;
        end
        CWAIT: begin
          state_q   <= IDLE;
          cpu_ack_q <= 1'b1;
          if (rd_q) cpu_rdata_q <= ram_rdata;
        end
        default: begin
          state_q  <= IDLE;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: video slots, CPU access,
// end-of-line prefetch, ack back-to-back and reset abort.
module tb_vram_arbiter;

  logic        clk;
  logic        reset;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        display_on;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  vid_data;
  logic        vid_valid;

  int n_chk;
  int n_fail;

  vram_arbiter #(
    .VID_BASE(16'h4000),
    .H_MAX(799),
    .V_MAX(524)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hpos(hpos),
    .vpos(vpos),
    .display_on(display_on),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .vid_data(vid_data),
    .vid_valid(vid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start a new cycle: inputs change just after the rising edge
  task automatic adv(input logic [9:0] h);
    @(posedge clk);
    #1;
    hpos = h;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    hpos       = 10'd690;
    vpos       = 10'd100;
    display_on = 1'b0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    ram_rdata  = '0;
    #3 reset = 1'b0;
    smp();
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_ack", 32'(cpu_ack), 32'h0);
    chk("rst_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_vdata", 32'(vid_data), 32'h0);
    chk("rst_vvalid", 32'(vid_valid), 32'h0);
    adv(10'd698);
    reset = 1'b1;
    adv(10'd699);

    // CPU read in blanking
    adv(10'd700);
    cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 16'h1234; ram_rdata = 8'h5A;
    smp(); chk("rd_nogrant_yet", 32'(ram_addr), 32'h0);
    adv(10'd701);
    smp(); chk("rd_addr", 32'(ram_addr), 32'h1234);
    chk("rd_we", 32'(ram_we), 32'h0);
    chk("rd_ack_early", 32'(cpu_ack), 32'h0);
    adv(10'd702);
    smp(); chk("rd_ack_cwait", 32'(cpu_ack), 32'h0);
    adv(10'd703);
    smp(); chk("rd_ack", 32'(cpu_ack), 32'h1);
    chk("rd_data", 32'(cpu_rdata), 32'h5A);
    adv(10'd704);
    cpu_req = 1'b0;
    smp(); chk("rd_ack_pulse", 32'(cpu_ack), 32'h0);

    // CPU write held across ack
    adv(10'd710);
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 16'h0BEE; cpu_wdata = 8'h3C;
    adv(10'd711);
    smp(); chk("wr_we", 32'(ram_we), 32'h1);
    chk("wr_addr", 32'(ram_addr), 32'h0BEE);
    chk("wr_wdata", 32'(ram_wdata), 32'h3C);
    adv(10'd712);
    smp(); chk("wr_we_cwait", 32'(ram_we), 32'h0);
    adv(10'd713);
    smp(); chk("wr_ack", 32'(cpu_ack), 32'h1);
    chk("wr_rdata_hold", 32'(cpu_rdata), 32'h5A);
    adv(10'd714);
    smp(); chk("ack_cycle_nogrant", 32'(ram_we), 32'h0);
    adv(10'd715);
    cpu_req = 1'b0;
    smp(); chk("regrant_we", 32'(ram_we), 32'h1);
    adv(10'd716);
    adv(10'd717);
    smp(); chk("regrant_ack", 32'(cpu_ack), 32'h1);
    adv(10'd718);

    // Visible-area video fetch
    adv(10'd12);
    display_on = 1'b1; vpos = 10'd16; ram_rdata = 8'hA5;
    adv(10'd13);
    adv(10'd14);
    smp(); chk("vid_addr", 32'(ram_addr), 32'h4102);
    chk("vid_we", 32'(ram_we), 32'h0);
    adv(10'd15);
    smp(); chk("vid_valid_early", 32'(vid_valid), 32'h0);
    adv(10'd16);
    smp(); chk("vid_valid", 32'(vid_valid), 32'h1);
    chk("vid_data", 32'(vid_data), 32'hA5);
    adv(10'd17);
    smp(); chk("vid_valid_pulse", 32'(vid_valid), 32'h0);

    // CPU blocked by cblock, video first
    adv(10'd10);
    vpos = 10'd24;
    adv(10'd11);
    cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 16'h0042; ram_rdata = 8'h77;
    adv(10'd12);
    smp(); chk("cblk_12", 32'(ram_addr), 32'h4102);
    adv(10'd13);
    smp(); chk("cblk_13", 32'(ram_addr), 32'h4102);
    adv(10'd14);
    smp(); chk("cblk_vid_addr", 32'(ram_addr), 32'h4182);
    adv(10'd15);
    adv(10'd16);
    smp(); chk("cblk_vvalid", 32'(vid_valid), 32'h1);
    chk("cblk_vdata", 32'(vid_data), 32'h77);
    adv(10'd17);
    smp(); chk("cblk_cpu_addr", 32'(ram_addr), 32'h0042);
    adv(10'd18);
    smp(); chk("cblk_ack_18", 32'(cpu_ack), 32'h0);
    adv(10'd19);
    cpu_req = 1'b0;
    smp(); chk("cblk_ack_19", 32'(cpu_ack), 32'h1);
    chk("cblk_rdata", 32'(cpu_rdata), 32'h77);
    adv(10'd20);
    smp(); chk("cblk_ack_20", 32'(cpu_ack), 32'h0);

    // Last-line prefetch wraps to row 0, CPU held off in blanking
    adv(10'd795);
    display_on = 1'b0; vpos = 10'd524;
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 16'h2222; cpu_wdata = 8'h99;
    adv(10'd796);
    smp(); chk("eol_blk_796", 32'(ram_we), 32'h0);
    adv(10'd797);
    smp(); chk("eol_blk_797", 32'(ram_we), 32'h0);
    adv(10'd798);
    smp(); chk("eol_wrap_addr", 32'(ram_addr), 32'h4000);
    chk("eol_wrap_we", 32'(ram_we), 32'h0);
    adv(10'd799);
    adv(10'd0);
    vpos = 10'd0;
    smp(); chk("eol_vvalid", 32'(vid_valid), 32'h1);
    adv(10'd1);
    smp(); chk("eol_cpu_we", 32'(ram_we), 32'h1);
    chk("eol_cpu_addr", 32'(ram_addr), 32'h2222);
    adv(10'd2);
    adv(10'd3);
    cpu_req = 1'b0;
    smp(); chk("eol_cpu_ack", 32'(cpu_ack), 32'h1);
    adv(10'd4);

    // Mid-frame prefetch moves to next row
    adv(10'd796);
    vpos = 10'd23;
    adv(10'd797);
    adv(10'd798);
    smp(); chk("eol_next_row", 32'(ram_addr), 32'h4180);
    adv(10'd799);
    adv(10'd0);
    adv(10'd1);

    // Reset in the middle of a CPU write
    adv(10'd700);
    vpos = 10'd100;
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 16'h5555; cpu_wdata = 8'h11;
    adv(10'd701);
    smp(); chk("abort_we_pre", 32'(ram_we), 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("abort_we", 32'(ram_we), 32'h0);
    chk("abort_addr", 32'(ram_addr), 32'h0);
    chk("abort_ack", 32'(cpu_ack), 32'h0);
    adv(10'd702);
    reset = 1'b1;
    smp(); chk("abort_idle_we", 32'(ram_we), 32'h0);
    chk("abort_idle_ack", 32'(cpu_ack), 32'h0);
    adv(10'd703);
    smp(); chk("abort_regrant", 32'(ram_we), 32'h1);
    adv(10'd704);
    smp(); chk("abort_ack_704", 32'(cpu_ack), 32'h0);
    adv(10'd705);
    cpu_req = 1'b0;
    smp(); chk("abort_ack_705", 32'(cpu_ack), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The module SHALL have these parameters: VID_BASE, 16'h0000, video text-map base address; H_MAX, 799, last hpos of a line; V_MAX, 524, last vpos of a frame.
REQ-002 The module SHALL have these ports, clock and reset first:
clk  in  1  single clock, all state rising-edge
reset  in  1  asynchronous, active-low reset
hpos  in  10  horizontal position from sync generator
vpos  in  10  vertical position from sync generator
display_on  in  1  visible-area flag from sync generator
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1=write, 0=read, stable while cpu_req
cpu_addr  in  16  CPU address, stable while cpu_req
cpu_wdata  in  8  CPU write data, stable while cpu_req
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  CPU read data, valid when cpu_ack=1
ram_addr  out  16  RAM address, registered
ram_we  out  1  RAM write enable, registered
ram_wdata  out  8  RAM write data, registered
ram_rdata  in  8  synchronous RAM read data, 1-cycle latency after ram_addr
vid_data  out  8  current-cell tile byte, registered
vid_valid  out  1  one-cycle pulse when vid_data updates

Function
REQ-003 Single-port RAM SHALL be shared via FSM states IDLE, VID, VWAIT, CPU, CWAIT; one access in flight at a time.
REQ-004 vslot SHALL be true in a cycle with hpos[2:0]==5 and (display_on==1 or hpos==H_MAX-2).
REQ-005 cblock SHALL be true when hpos[2:0] is 3, 4 or 5 and (display_on==1 or H_MAX-4 <= hpos <= H_MAX-2).
REQ-006 IDLE with vslot SHALL go to VID; video has absolute priority over CPU.
REQ-007 IDLE with cpu_req=1, cblock=0 and cpu_ack=0 SHALL go to CPU; otherwise remain IDLE.
REQ-008 In VID, ram_addr SHALL = VID_BASE + {3'b0, row[5:0], col[6:0]} (16-bit wrap), ram_we=0, where col=hpos[9:3]+1 and row=vpos[8:3] for the fetch issued during display_on.
REQ-009 For the fetch at hpos==H_MAX-2, col SHALL be 0 and row SHALL be ((vpos==V_MAX)?0:vpos+1)[8:3].
REQ-010 VID SHALL always go to VWAIT; VWAIT SHALL go to IDLE, capturing ram_rdata into vid_data and setting vid_valid=1 for exactly the following cycle (hpos[2:0]==0 of the next cell).
REQ-011 In CPU, ram_addr SHALL = cpu_addr, ram_we = cpu_we, ram_wdata = cpu_wdata; CPU SHALL go to CWAIT.
REQ-012 In CWAIT, ram_we SHALL be 0; on exit to IDLE cpu_rdata SHALL capture ram_rdata on reads (hold previous value on writes) and cpu_ack SHALL be 1 for exactly the next cycle.
REQ-013 Latency: CPU grant to cpu_ack SHALL be 3 cycles (CPU, CWAIT, ack cycle).
REQ-014 No new CPU grant SHALL occur in a cycle with cpu_ack=1, even if cpu_req stays high.
REQ-015 ram_we SHALL be 1 only in CPU state with cpu_we=1; in IDLE, ram_addr/ram_wdata SHALL hold, ram_we=0.
REQ-016 cblock SHALL guarantee every vslot finds the FSM in IDLE; no video fetch is ever skipped.
REQ-017 Simultaneous vslot and cpu_req SHALL grant video; CPU waits, no request lost.

Reset
REQ-018 reset=0 SHALL immediately force IDLE, ram_we=0, ram_addr=0, ram_wdata=0, cpu_ack=0, cpu_rdata=0, vid_data=0, vid_valid=0.
REQ-019 Reset mid-access SHALL abort it with no cpu_ack; a still-asserted cpu_req SHALL be regranted after reset release.
REQ-020 After reset release, the first cycle SHALL be IDLE, evaluated normally.

Verification
REQ-021 Reset during CPU write (ram_we=1) -> ram_we=0 and state IDLE before next clk edge; no cpu_ack.
REQ-022 VID_BASE=16'h4000, vpos=16, hpos=13, display_on=1, ram_rdata=8'hA5 -> ram_addr=16'h4102 at hpos=14; vid_data=8'hA5, vid_valid=1 at hpos=16 only.
REQ-023 display_on=0, hpos=700, cpu read addr 16'h1234, ram_rdata=8'h5A -> ram_addr=16'h1234 next cycle; cpu_ack=1, cpu_rdata=8'h5A two cycles later.
REQ-024 display_on=1, cpu_req at hpos=11 -> no grant at 11..13; VID at 14, CPU at 17, cpu_ack at 19.
REQ-025 vpos=524, hpos=797 -> ram_addr=VID_BASE at hpos=798 (row 0, col 0).
REQ-026 cpu_req held high across cpu_ack -> no grant in ack cycle; second grant next cycle.
